rabi_pulse_scheduler: RTL and testbench
=======================================

Name: rabi_pulse_scheduler

Overview:
Sequences one experimental shot per external trigger. Each shot is a delay, then an RF pulse, then a gap, then a Raman (Rabi) pulse whose width steps up by a fixed increment on each successive shot. This produces a Rabi-oscillation scan. The block sits between the MKR trigger pins and the rf/rabi output pins, and runs on the internal 80 MHz oscillator clock.

Parameters:
CNT_W, 24, width of all duration counters and the computed Raman width
RF_DELAY, 16, cycles from trigger event to RF rising edge (0 = no delay phase)
RF_WIDTH, 80, RF pulse width in cycles (0 = RF phase skipped)
GAP, 8, cycles between RF falling and Raman rising (0 = no gap phase)
RABI_BASE, 8, Raman width at scan index 0, in cycles
RABI_STEP, 8, Raman width increment per scan index, in cycles
N_STEPS, 64, scan length (must be ≥1); index wraps N_STEPS-1 → 0
IDX_W, 8, width of the scan index

Ports:
iCLK  in  1  system clock (80 MHz oscillator)
iRESETn  in  1  asynchronous active-low reset
iEN  in  1  trigger enable, synchronous level
iTRIG  in  1  shot trigger pin, asynchronous, rising-edge active
iSCAN_RST  in  1  scan restart pin, asynchronous, rising-edge active
oRF  out  1  RF pulse output, registered
oRABI  out  1  Raman pulse output, registered
oBUSY  out  1  high while a shot is in progress
oDONE  out  1  one-cycle pulse at end of shot
oSCAN_WRAP  out  1  one-cycle pulse when the index wraps to 0
oSTEP_IDX  out  IDX_W  scan index to be used by the next shot
oMISSED  out  8  saturating count of triggers ignored while busy

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; index 0; missed count 0; synchronizer flops 0.
- iTRIG and iSCAN_RST each pass through a 2-FF synchronizer plus a registered rising-edge detector. The "event" cycle E is the cycle the detector output is high, 3 cycles after the pin edge.
- States: IDLE → DELAY → RF → GAP → RABI → DONE → IDLE. A phase of zero length is skipped; its successor is entered directly in the same transition.
- IDLE: a trigger event with iEN=1 latches W = RABI_BASE + idx*RABI_STEP. W is computed at full precision and saturated to 2^CNT_W-1. The block enters the first non-empty phase at E+1. A trigger event with iEN=0 is dropped silently.
- Each phase of length L occupies exactly L cycles. oRF is high exactly during RF cycles; oRABI is high exactly during RABI cycles. If W=0, RABI is skipped.
- DONE lasts 1 cycle. During DONE: oDONE=1; index increments, wrapping N_STEPS-1 → 0 with oSCAN_WRAP=1. The next cycle is IDLE.
- oBUSY is high in every state except IDLE.
- Trigger event while not IDLE: the event is ignored, oMISSED increments, saturating at 255. The shot in progress is unaffected.
- Scan-restart event: index is set to 0 in the next cycle. If it occurs mid-shot, the current shot keeps its latched W. If it coincides with DONE, the restart wins: index becomes 0 and oSCAN_WRAP stays 0.
- A trigger event and a restart event in the same IDLE cycle: the restart takes priority for the index, so that shot uses idx 0.
- iEN falling mid-shot has no effect on the shot in progress.
- Async reset mid-shot: oRF and oRABI drop immediately, and the block returns to the reset state.

Test Plan:
(All use RF_DELAY=4, RF_WIDTH=10, GAP=3, RABI_BASE=5, RABI_STEP=2, N_STEPS=4.)
- Single shot, idx 0, trigger at E: oBUSY high E+1..E+23; oRF high E+5..E+14; oRABI high E+18..E+22 (5 cycles); oDONE at E+23; oSTEP_IDX=1 at E+24.
- Four consecutive shots: oRABI widths 5, 7, 9, 11 cycles; oSCAN_WRAP pulses at the 4th DONE; oSTEP_IDX returns to 0; fifth shot width 5.
- Second iTRIG edge 8 cycles after the first: no effect on oRF/oRABI timing; oMISSED=1. Then 300 such edges: oMISSED stays at 255.
- iSCAN_RST pulsed during RF of the idx-2 shot: that shot's Raman width is 9; next shot width 5. Restart coincident with DONE: oSTEP_IDX=0, oSCAN_WRAP=0.
- iEN=0 with iTRIG edge: oBUSY stays 0, oMISSED unchanged. Separately, iRESETn pulled low during RABI: oRABI=0 in the same cycle, index and oMISSED read 0 after release.
- Params RF_DELAY=0, GAP=0, RABI_BASE=0, RABI_STEP=0: oRF rises at E+1; the RABI phase is skipped; oDONE at E+11.

Source files
------------

// File: rtl/rabi_pulse_scheduler_if.sv
// Pin-side signal bundle for the Rabi pulse scheduler.
// The master side drives the trigger/enable pins and observes the pulse
// outputs. The slave side is the scheduler itself.
interface rabi_pulse_scheduler_if #(
    parameter int IDX_W = 8
);
    logic             iEN;
    logic             iTRIG;
    logic             iSCAN_RST;
    logic             oRF;
    logic             oRABI;
    logic             oBUSY;
    logic             oDONE;
    logic             oSCAN_WRAP;
    logic [IDX_W-1:0] oSTEP_IDX;
    logic [7:0]       oMISSED;

    modport master (
        output iEN, iTRIG, iSCAN_RST,
        input  oRF, oRABI, oBUSY, oDONE, oSCAN_WRAP, oSTEP_IDX, oMISSED
    );

    modport slave (
        input  iEN, iTRIG, iSCAN_RST,
        output oRF, oRABI, oBUSY, oDONE, oSCAN_WRAP, oSTEP_IDX, oMISSED
    );
endinterface

// File: rtl/rabi_pulse_scheduler.sv
// Rabi scan shot sequencer.
// Each trigger runs one shot: delay, RF pulse, gap, Raman pulse, done.
// The Raman width grows by RABI_STEP on each shot and wraps after N_STEPS shots.
// Trigger and scan-restart pins are asynchronous. Each pin is synchronised and
// edge-detected before use.
module rabi_pulse_scheduler #(
    parameter int CNT_W     = 24,
    parameter int RF_DELAY  = 16,
    parameter int RF_WIDTH  = 80,
    parameter int GAP       = 8,
    parameter int RABI_BASE = 8,
    parameter int RABI_STEP = 8,
    parameter int N_STEPS   = 64,
    parameter int IDX_W     = 8
) (
    input  logic                   iCLK,
    input  logic                   iRESETn,
    rabi_pulse_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        RF    = 3'd2,
        GAP_S = 3'd3,
        RABI  = 3'd4,
        DONE  = 3'd5
    } stateT;

    localparam logic [CNT_W-1:0] LEN_DELAY = CNT_W'(RF_DELAY);
    localparam logic [CNT_W-1:0] LEN_RF    = CNT_W'(RF_WIDTH);
    localparam logic [CNT_W-1:0] LEN_GAP   = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STEPS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [63:0]      W_MAX     = (64'd1 << CNT_W) - 64'd1;

    logic [1:0]       trigSync;
    logic [1:0]       scanSync;
    logic             trigPrev;
    logic             scanPrev;
    logic             trigEvt;
    logic             scanEvt;

    stateT            state;
    stateT            stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [CNT_W-1:0] wLatched;
    logic [CNT_W-1:0] wNext;
    logic [CNT_W-1:0] wNew;
    logic [63:0]      wFull;
    logic [IDX_W-1:0] idxForShot;

    logic [IDX_W-1:0] stepIdx;
    logic [IDX_W-1:0] idxNext;
    logic             restartPend;
    logic             pendNext;
    logic [7:0]       missed;
    logic [7:0]       missedNext;
    logic             rfReg;
    logic             rabiReg;

    // Jump over any zero-length phases, starting from the requested one.
    function automatic stateT skipEmpty(input stateT s, input logic [CNT_W-1:0] w);
        stateT r;
        r = s;
        if (r == DELAY && LEN_DELAY == '0) r = RF;
        if (r == RF    && LEN_RF    == '0) r = GAP_S;
        if (r == GAP_S && LEN_GAP   == '0) r = RABI;
        if (r == RABI  && w         == '0) r = DONE;
        return r;
    endfunction

    // Duration of a phase. Only the Raman phase has a per-shot width.
    function automatic logic [CNT_W-1:0] phaseLen(input stateT s, input logic [CNT_W-1:0] w);
        logic [CNT_W-1:0] len;
        case (s)
            DELAY:   len = LEN_DELAY;
            RF:      len = LEN_RF;
            GAP_S:   len = LEN_GAP;
            RABI:    len = w;
            default: len = '0;
        endcase
        return len;
    endfunction

    // Phase that naturally follows the current one before skipping is applied.
    function automatic stateT successor(input stateT s);
        stateT r;
        case (s)
            DELAY:   r = RF;
            RF:      r = GAP_S;
            GAP_S:   r = RABI;
            RABI:    r = DONE;
            default: r = IDLE;
        endcase
        return r;
    endfunction

    // Two-flop synchronisers plus registered rising-edge detectors for both pins.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            trigSync <= 2'b00;
            scanSync <= 2'b00;
            trigPrev <= 1'b0;
            scanPrev <= 1'b0;
            trigEvt  <= 1'b0;
            scanEvt  <= 1'b0;
        end else begin
            trigSync <= {trigSync[0], bus.iTRIG};
            scanSync <= {scanSync[0], bus.iSCAN_RST};
            trigPrev <= trigSync[1];
            scanPrev <= scanSync[1];
            trigEvt  <= trigSync[1] & ~trigPrev;
            scanEvt  <= scanSync[1] & ~scanPrev;
        end
    end

    // Raman width for a shot starting now. A restart arriving in the same
    // cycle forces index 0. The product is formed wide and clamped to the counter range.
    always_comb begin
        idxForShot = scanEvt ? '0 : stepIdx;
        wFull      = 64'(RABI_BASE) + 64'(idxForShot) * 64'(RABI_STEP);
        wNew       = (wFull > W_MAX) ? {CNT_W{1'b1}} : wFull[CNT_W-1:0];
    end

    // Phase sequencing. The counter is loaded with length-1 on entry and
    // the phase ends when it reaches zero.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        wNext     = wLatched;
        case (state)
            IDLE: begin
                if (trigEvt && bus.iEN) begin
                    stateNext = skipEmpty(DELAY, wNew);
                    wNext     = wNew;
                    cntNext   = phaseLen(stateNext, wNew) - CNT_ONE;
                end
            end
            DELAY, RF, GAP_S, RABI: begin
                if (cnt == '0) begin
                    stateNext = skipEmpty(successor(state), wLatched);
                    cntNext   = phaseLen(stateNext, wLatched) - CNT_ONE;
                end else begin
                    cntNext   = cnt - CNT_ONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Scan index bookkeeping. A restart seen during a shot makes the next
    // shot start the scan from 0, so the end-of-shot increment is suppressed.
    always_comb begin
        idxNext  = stepIdx;
        pendNext = restartPend;
        if (state == DONE) begin
            pendNext = 1'b0;
            if (scanEvt || restartPend) begin
                idxNext = '0;
            end else if (stepIdx == LAST_IDX) begin
                idxNext = '0;
            end else begin
                idxNext = stepIdx + IDX_ONE;
            end
        end else if (scanEvt) begin
            idxNext = '0;
            if (state != IDLE) pendNext = 1'b1;
        end
    end

    // Count triggers that arrive while a shot is already running, saturating at 255.
    always_comb begin
        missedNext = missed;
        if (trigEvt && state != IDLE && missed != 8'hFF) begin
            missedNext = missed + 8'd1;
        end
    end

    // State and datapath registers. The pulse outputs are registered from
    // the next state, so they line up exactly with their phases.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state       <= IDLE;
            cnt         <= '0;
            wLatched    <= '0;
            stepIdx     <= '0;
            restartPend <= 1'b0;
            missed      <= 8'd0;
            rfReg       <= 1'b0;
            rabiReg     <= 1'b0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            wLatched    <= wNext;
            stepIdx     <= idxNext;
            restartPend <= pendNext;
            missed      <= missedNext;
            rfReg       <= (stateNext == RF);
            rabiReg     <= (stateNext == RABI);
        end
    end

    assign bus.oRF        = rfReg;
    assign bus.oRABI      = rabiReg;
    assign bus.oBUSY      = (state != IDLE);
    assign bus.oDONE      = (state == DONE);
    assign bus.oSCAN_WRAP = (state == DONE) && !scanEvt && !restartPend && (stepIdx == LAST_IDX);
    assign bus.oSTEP_IDX  = stepIdx;
    assign bus.oMISSED    = missed;

endmodule

// File: tb/tb_rabi_pulse_scheduler.sv
// Directed bench for the Rabi pulse scheduler.
// DUT A uses the reference parameter set. DUT B has every optional phase
// collapsed to zero and checks phase skipping.
module tb_rabi_pulse_scheduler;

    logic iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    logic iRESETn;
    logic en;
    logic trig;
    logic scanRst;

    rabi_pulse_scheduler_if #(.IDX_W(8)) busA ();
    rabi_pulse_scheduler_if #(.IDX_W(8)) busB ();

    assign busA.iEN       = en;
    assign busA.iTRIG     = trig;
    assign busA.iSCAN_RST = scanRst;
    assign busB.iEN       = en;
    assign busB.iTRIG     = trig;
    assign busB.iSCAN_RST = scanRst;

    rabi_pulse_scheduler #(
        .CNT_W(24), .RF_DELAY(4), .RF_WIDTH(10), .GAP(3),
        .RABI_BASE(5), .RABI_STEP(2), .N_STEPS(4), .IDX_W(8)
    ) dutA (
        .iCLK(iCLK), .iRESETn(iRESETn), .bus(busA)
    );

    rabi_pulse_scheduler #(
        .CNT_W(24), .RF_DELAY(0), .RF_WIDTH(10), .GAP(0),
        .RABI_BASE(0), .RABI_STEP(0), .N_STEPS(4), .IDX_W(8)
    ) dutB (
        .iCLK(iCLK), .iRESETn(iRESETn), .bus(busB)
    );

    typedef struct {
        int scanRel;
        int trig2Rel;
        int expRabiW;
        int expWrap;
        int expIdx;
        int expMissed;
    } shotVecT;

    shotVecT vecs[14];

    int checks = 0;
    int errors = 0;

    logic [37:0] rfA, rabiA, busyA, doneA, wrapA;
    logic [37:0] rfB, rabiB, busyB, doneB;
    int idxAfter;
    int missedAfter;

    function automatic int firstHigh(input logic [37:0] v);
        for (int i = 0; i < 38; i++) if (v[i]) return i - 3;
        return -1;
    endfunction

    function automatic int lastHigh(input logic [37:0] v);
        for (int i = 37; i >= 0; i--) if (v[i]) return i - 3;
        return -1;
    endfunction

    function automatic int countHigh(input logic [37:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 38; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One shot. Cycle rel=0 is the trigger event cycle E, and the pin rises at rel=-3.
    task automatic applyStimulus(input int scanRel, input int trig2Rel);
        for (int rel = -3; rel <= 34; rel++) begin
            rfA[rel+3]   = busA.oRF;
            rabiA[rel+3] = busA.oRABI;
            busyA[rel+3] = busA.oBUSY;
            doneA[rel+3] = busA.oDONE;
            wrapA[rel+3] = busA.oSCAN_WRAP;
            rfB[rel+3]   = busB.oRF;
            rabiB[rel+3] = busB.oRABI;
            busyB[rel+3] = busB.oBUSY;
            doneB[rel+3] = busB.oDONE;
            if (rel == -3) trig = 1'b1;
            if (rel == 0)  trig = 1'b0;
            if (trig2Rel >= 0 && rel == trig2Rel)     trig = 1'b1;
            if (trig2Rel >= 0 && rel == trig2Rel + 3) trig = 1'b0;
            if (scanRel >= 0 && rel == scanRel)       scanRst = 1'b1;
            if (scanRel >= 0 && rel == scanRel + 3)   scanRst = 1'b0;
            @(posedge iCLK);
            #1;
        end
        idxAfter    = int'(busA.oSTEP_IDX);
        missedAfter = int'(busA.oMISSED);
    endtask

    initial begin
        iRESETn = 1'b0;
        en      = 1'b1;
        trig    = 1'b0;
        scanRst = 1'b0;

        vecs[0]  = '{-1, -1,  5, 0, 1, 0};
        vecs[1]  = '{-1,  5,  7, 0, 2, 1};
        vecs[2]  = '{-1, -1,  9, 0, 3, 1};
        vecs[3]  = '{-1, -1, 11, 1, 0, 1};
        vecs[4]  = '{-1, -1,  5, 0, 1, 1};
        vecs[5]  = '{-1, -1,  7, 0, 2, 1};
        vecs[6]  = '{ 6, -1,  9, 0, 0, 1};
        vecs[7]  = '{-1, -1,  5, 0, 1, 1};
        vecs[8]  = '{22, -1,  7, 0, 0, 1};
        vecs[9]  = '{-1, -1,  5, 0, 1, 1};
        vecs[10] = '{-1, -1,  7, 0, 2, 1};
        vecs[11] = '{-1, -1,  9, 0, 3, 1};
        vecs[12] = '{26, -1, 11, 0, 0, 1};
        vecs[13] = '{-1, -1,  5, 0, 1, 1};

        repeat (3) @(posedge iCLK);
        #1;
        checkOutput("reset oRF",        int'(busA.oRF), 0);
        checkOutput("reset oRABI",      int'(busA.oRABI), 0);
        checkOutput("reset oBUSY",      int'(busA.oBUSY), 0);
        checkOutput("reset oDONE",      int'(busA.oDONE), 0);
        checkOutput("reset oSCAN_WRAP", int'(busA.oSCAN_WRAP), 0);
        checkOutput("reset oSTEP_IDX",  int'(busA.oSTEP_IDX), 0);
        checkOutput("reset oMISSED",    int'(busA.oMISSED), 0);
        @(negedge iCLK);
        iRESETn = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].scanRel, vecs[i].trig2Rel);
            checkOutput($sformatf("shot%0d rf first", i),   firstHigh(rfA), 5);
            checkOutput($sformatf("shot%0d rf last", i),    lastHigh(rfA), 14);
            checkOutput($sformatf("shot%0d rabi first", i), firstHigh(rabiA), 18);
            checkOutput($sformatf("shot%0d rabi width", i), countHigh(rabiA), vecs[i].expRabiW);
            checkOutput($sformatf("shot%0d rabi last", i),  lastHigh(rabiA), 17 + vecs[i].expRabiW);
            checkOutput($sformatf("shot%0d done at", i),    firstHigh(doneA), 18 + vecs[i].expRabiW);
            checkOutput($sformatf("shot%0d done width", i), countHigh(doneA), 1);
            checkOutput($sformatf("shot%0d busy first", i), firstHigh(busyA), 1);
            checkOutput($sformatf("shot%0d busy width", i), countHigh(busyA), 18 + vecs[i].expRabiW);
            checkOutput($sformatf("shot%0d wrap at", i),    firstHigh(wrapA),
                        (vecs[i].expWrap != 0) ? 18 + vecs[i].expRabiW : -1);
            checkOutput($sformatf("shot%0d wrap width", i), countHigh(wrapA), vecs[i].expWrap);
            checkOutput($sformatf("shot%0d idx after", i),  idxAfter, vecs[i].expIdx);
            checkOutput($sformatf("shot%0d missed", i),     missedAfter, vecs[i].expMissed);
            if (i == 0) begin
                checkOutput("zeroParams rf first",   firstHigh(rfB), 1);
                checkOutput("zeroParams rf last",    lastHigh(rfB), 10);
                checkOutput("zeroParams rabi count", countHigh(rabiB), 0);
                checkOutput("zeroParams done at",    firstHigh(doneB), 11);
                checkOutput("zeroParams busy width", countHigh(busyB), 11);
            end
        end

        // Disabled trigger is dropped without counting as missed.
        en = 1'b0;
        applyStimulus(-1, -1);
        checkOutput("disabled busy",   countHigh(busyA), 0);
        checkOutput("disabled missed", missedAfter, 1);
        checkOutput("disabled idx",    idxAfter, 1);
        en = 1'b1;

        // A burst of trigger edges saturates the missed counter.
        for (int k = 0; k < 300; k++) begin
            trig = 1'b1;
            @(posedge iCLK);
            #1;
            trig = 1'b0;
            @(posedge iCLK);
            #1;
        end
        repeat (40) @(posedge iCLK);
        #1;
        checkOutput("burst missed sat", int'(busA.oMISSED), 255);
        checkOutput("burst idle", int'(busA.oBUSY), 0);

        // Asynchronous reset in the middle of the Raman pulse.
        for (int rel = -3; rel < 19; rel++) begin
            if (rel == -3) trig = 1'b1;
            if (rel == 0)  trig = 1'b0;
            @(posedge iCLK);
            #1;
        end
        checkOutput("midshot rabi high", int'(busA.oRABI), 1);
        #2;
        iRESETn = 1'b0;
        #1;
        checkOutput("async rst rabi", int'(busA.oRABI), 0);
        checkOutput("async rst rf",   int'(busA.oRF), 0);
        checkOutput("async rst busy", int'(busA.oBUSY), 0);
        @(negedge iCLK);
        iRESETn = 1'b1;
        repeat (2) @(posedge iCLK);
        #1;
        checkOutput("post rst idx",    int'(busA.oSTEP_IDX), 0);
        checkOutput("post rst missed", int'(busA.oMISSED), 0);
        checkOutput("post rst busy",   int'(busA.oBUSY), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
